// File: rtl/sha3_chi_inverse.sv
// sha3_chi_inverse
//   Recovers the chi-input state of a Keccak round from its chi-output state.
//   Each 5-bit row (one bit from each lane of a slice) is mapped through a
//   fixed 32-entry inverse table. BITS_PER_CYCLE bit columns of all five
//   slices are inverted per BUSY cycle, so one state takes 64/BITS_PER_CYCLE
//   cycles.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   isa..ise [4:0][63:0] chi-output state, slice s = isa..ise, lane c = index
//   sample              capture the input state and start (accepted in IDLE)
//   osa..ose [4:0][63:0] recovered chi-input state, same layout
//   ogood               one-cycle pulse when a new result is presented
//   oready              high while IDLE
module sha3_chi_inverse #(
  parameter int BITS_PER_CYCLE = 8,
  parameter int OUTPUT_BUFFER  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  input  logic            sample,
  output logic [4:0][63:0] osa,
  output logic [4:0][63:0] osb,
  output logic [4:0][63:0] osc,
  output logic [4:0][63:0] osd,
  output logic [4:0][63:0] ose,
  output logic            ogood,
  output logic            oready
);

  localparam int STEPS = 64 / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // [slice][lane][bit]
  typedef logic [4:0][4:0][63:0] lanes_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lanes_t           work_q, work_d;
  logic             ogood_q, ogood_d;
  lanes_t           out_s;

  // Inverse of chi on one 5-bit row: returns x such that chi(x) == y.
  function automatic logic [4:0] chi_inv_row(input logic [4:0] y);
    logic [4:0] x;
    case (y)
      5'd0:  x = 5'd0;
      5'd1:  x = 5'd11;
      5'd2:  x = 5'd22;
      5'd3:  x = 5'd9;
      5'd4:  x = 5'd13;
      5'd5:  x = 5'd4;
      5'd6:  x = 5'd18;
      5'd7:  x = 5'd15;
      5'd8:  x = 5'd26;
      5'd9:  x = 5'd1;
      5'd10: x = 5'd8;
      5'd11: x = 5'd3;
      5'd12: x = 5'd5;
      5'd13: x = 5'd12;
      5'd14: x = 5'd30;
      5'd15: x = 5'd7;
      5'd16: x = 5'd21;
      5'd17: x = 5'd20;
      5'd18: x = 5'd2;
      5'd19: x = 5'd23;
      5'd20: x = 5'd16;
      5'd21: x = 5'd17;
      5'd22: x = 5'd6;
      5'd23: x = 5'd19;
      5'd24: x = 5'd10;
      5'd25: x = 5'd27;
      5'd26: x = 5'd24;
      5'd27: x = 5'd25;
      5'd28: x = 5'd29;
      5'd29: x = 5'd28;
      5'd30: x = 5'd14;
      5'd31: x = 5'd31;
      default: x = 5'd0;
    endcase
    return x;
  endfunction

  // Next-state logic: capture in IDLE, invert one column group per BUSY cycle.
  always_comb begin
    logic [5:0] base;
    logic [5:0] col;
    logic [4:0] row;
    logic [4:0] row_inv;
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    ogood_d = 1'b0;
    base    = 6'(int'(cnt_q) * BITS_PER_CYCLE);
    col     = 6'd0;
    row     = 5'd0;
    row_inv = 5'd0;
    case (state_q)
      IDLE: begin
        if (sample) begin
          work_d  = {ise, isd, isc, isb, isa};
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Rows read from work_q: each row lives in a single column, so
        // in-place replacement of the current group never aliases.
        for (int s = 0; s < 5; s++) begin
          for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            col = base + 6'(j);
            for (int c = 0; c < 5; c++) begin
              row[c] = work_q[s][c][col];
            end
            row_inv = chi_inv_row(row);
            for (int c = 0; c < 5; c++) begin
              work_d[s][c][col] = row_inv[c];
            end
          end
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          ogood_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and working-state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      ogood_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      ogood_q <= ogood_d;
    end
  end

  if (OUTPUT_BUFFER != 0) begin : g_obuf
    lanes_t res_q, res_d;

    // Result register loads the finished state on the completing edge.
    always_comb begin
      if (ogood_d) begin
        res_d = work_d;
      end else begin
        res_d = res_q;
      end
    end

    // Result register storage.
    always_ff @(posedge clk) begin
      if (rst) begin
        res_q <= '0;
      end else begin
        res_q <= res_d;
      end
    end

    assign out_s = res_q;
  end else begin : g_direct
    // Working register doubles as the result; meaningless while BUSY.
    assign out_s = work_q;
  end

  assign osa    = out_s[0];
  assign osb    = out_s[1];
  assign osc    = out_s[2];
  assign osd    = out_s[3];
  assign ose    = out_s[4];
  assign ogood  = ogood_q;
  assign oready = (state_q == IDLE);

endmodule

// File: tb/tb_sha3_chi_inverse.sv
// Testbench for sha3_chi_inverse: three instances (B=8 buffered, B=1 direct,
// B=64 buffered) driven one at a time from a shared input state.
module tb_sha3_chi_inverse;

  typedef logic [4:0][4:0][63:0] state_t;
  typedef struct {
    state_t din;
    state_t dout;
  } vec_t;

  localparam int NV = 7;

  logic   clk;
  logic   rst;
  state_t in_st;
  logic   s8, s1, s64;
  state_t o8, o1, o64;
  logic   g8, r8, g1, r1, g64, r64;
  int     checks;
  int     failures;
  vec_t   vecs [NV];

  sha3_chi_inverse #(.BITS_PER_CYCLE(8), .OUTPUT_BUFFER(1)) dut8 (
    .clk(clk), .rst(rst),
    .isa(in_st[0]), .isb(in_st[1]), .isc(in_st[2]), .isd(in_st[3]), .ise(in_st[4]),
    .sample(s8),
    .osa(o8[0]), .osb(o8[1]), .osc(o8[2]), .osd(o8[3]), .ose(o8[4]),
    .ogood(g8), .oready(r8)
  );

  sha3_chi_inverse #(.BITS_PER_CYCLE(1), .OUTPUT_BUFFER(0)) dut1 (
    .clk(clk), .rst(rst),
    .isa(in_st[0]), .isb(in_st[1]), .isc(in_st[2]), .isd(in_st[3]), .ise(in_st[4]),
    .sample(s1),
    .osa(o1[0]), .osb(o1[1]), .osc(o1[2]), .osd(o1[3]), .ose(o1[4]),
    .ogood(g1), .oready(r1)
  );

  sha3_chi_inverse #(.BITS_PER_CYCLE(64), .OUTPUT_BUFFER(1)) dut64 (
    .clk(clk), .rst(rst),
    .isa(in_st[0]), .isb(in_st[1]), .isc(in_st[2]), .isd(in_st[3]), .ise(in_st[4]),
    .sample(s64),
    .osa(o64[0]), .osb(o64[1]), .osc(o64[2]), .osd(o64[3]), .ose(o64[4]),
    .ogood(g64), .oready(r64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int sel);
    case (sel)
      0:       return 9;
      1:       return 65;
      default: return 2;
    endcase
  endfunction

  function automatic state_t get_out(input int sel);
    case (sel)
      0:       return o8;
      1:       return o1;
      default: return o64;
    endcase
  endfunction

  function automatic logic get_good(input int sel);
    case (sel)
      0:       return g8;
      1:       return g1;
      default: return g64;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return r8;
      1:       return r1;
      default: return r64;
    endcase
  endfunction

  task automatic set_sample(input int sel, input logic v);
    case (sel)
      0:       s8 = v;
      1:       s1 = v;
      default: s64 = v;
    endcase
  endtask

  // Reference forward chi applied to every slice.
  function automatic state_t chi_state(input state_t x);
    state_t y;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 5; c++) begin
        y[s][c] = x[s][c] ^ (~x[s][(c + 1) % 5] & x[s][(c + 2) % 5]);
      end
    end
    return y;
  endfunction

  function automatic state_t rand_state();
    state_t x;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 5; c++) begin
        x[s][c] = {$urandom, $urandom};
      end
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic ok, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_state(input string nm, input state_t act, input state_t req);
    int fs;
    int fc;
    logic found;
    fs = 0;
    fc = 0;
    found = 1'b0;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 5; c++) begin
        if (!found && (act[s][c] !== req[s][c])) begin
          fs = s;
          fc = c;
          found = 1'b1;
        end
      end
    end
    chk($sformatf("%s[slice%0d lane%0d]", nm, fs, fc), act === req, act[fs][fc], req[fs][fc]);
  endtask

  // One isolated operation; starts and ends on a falling edge.
  task automatic run_op(input int sel, input state_t din, input state_t dout, input string nm);
    int lat;
    int bad;
    lat = lat_of(sel);
    bad = 0;
    chk({nm, " ready_before"}, get_ready(sel) === 1'b1, 64'(get_ready(sel)), 64'd1);
    in_st = din;
    set_sample(sel, 1'b1);
    for (int n = 1; n < lat; n++) begin
      @(negedge clk);
      set_sample(sel, 1'b0);
      if (get_ready(sel) !== 1'b0 || get_good(sel) !== 1'b0) bad++;
    end
    chk({nm, " busy_flags"}, bad == 0, 64'(bad), 64'd0);
    @(negedge clk);
    chk({nm, " ogood_at_latency"}, get_good(sel) === 1'b1, 64'(get_good(sel)), 64'd1);
    chk({nm, " ready_at_latency"}, get_ready(sel) === 1'b1, 64'(get_ready(sel)), 64'd1);
    chk_state({nm, " result"}, get_out(sel), dout);
    @(negedge clk);
    chk({nm, " ogood_single"}, get_good(sel) === 1'b0, 64'(get_good(sel)), 64'd0);
    chk_state({nm, " result_hold"}, get_out(sel), dout);
  endtask

  // Reset in the middle of an operation, then a normal run straight after.
  task automatic reset_mid(input int sel);
    int lat;
    int rp;
    int bad;
    state_t zero;
    lat  = lat_of(sel);
    rp   = (lat - 1 < 4) ? lat - 1 : 4;
    bad  = 0;
    zero = '0;
    in_st = rand_state();
    set_sample(sel, 1'b1);
    for (int n = 1; n <= rp; n++) begin
      @(negedge clk);
      set_sample(sel, 1'b0);
      if (get_good(sel) !== 1'b0) bad++;
    end
    chk($sformatf("rstmid%0d busy_before_rst", sel), get_ready(sel) === 1'b0,
        64'(get_ready(sel)), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk($sformatf("rstmid%0d no_early_ogood", sel), bad == 0, 64'(bad), 64'd0);
    chk($sformatf("rstmid%0d ogood", sel), get_good(sel) === 1'b0, 64'(get_good(sel)), 64'd0);
    chk($sformatf("rstmid%0d ready", sel), get_ready(sel) === 1'b1, 64'(get_ready(sel)), 64'd1);
    chk_state($sformatf("rstmid%0d outputs_zero", sel), get_out(sel), zero);
    run_op(sel, vecs[1].din, vecs[1].dout, $sformatf("after_rst%0d", sel));
  endtask

  // Back-to-back random operations, a new sample on every completion cycle.
  task automatic b2b(input int sel, input int count);
    int lat;
    int rlow;
    int rhigh;
    int bgood;
    state_t orig;
    lat   = lat_of(sel);
    rlow  = 0;
    rhigh = 0;
    bgood = 0;
    for (int i = 0; i < count; i++) begin
      orig  = rand_state();
      in_st = chi_state(orig);
      set_sample(sel, 1'b1);
      for (int n = 1; n < lat; n++) begin
        @(negedge clk);
        set_sample(sel, 1'b0);
        if (get_ready(sel) === 1'b0) rlow++;
        if (get_good(sel) !== 1'b0) bgood++;
      end
      @(negedge clk);
      if (get_ready(sel) === 1'b1) rhigh++;
      chk($sformatf("b2b%0d ogood #%0d", sel, i), get_good(sel) === 1'b1,
          64'(get_good(sel)), 64'd1);
      chk_state($sformatf("b2b%0d result #%0d", sel, i), get_out(sel), orig);
    end
    set_sample(sel, 1'b0);
    chk($sformatf("b2b%0d ready_low_cycles", sel), rlow == count * (lat - 1),
        64'(rlow), 64'(count * (lat - 1)));
    chk($sformatf("b2b%0d ready_high_cycles", sel), rhigh == count, 64'(rhigh), 64'(count));
    chk($sformatf("b2b%0d stray_ogood", sel), bgood == 0, 64'(bgood), 64'd0);
  endtask

  // Sample held high while BUSY with changing inputs must be ignored.
  task automatic held_sample();
    int extra;
    int early;
    state_t ones;
    extra = 0;
    early = 0;
    ones  = '1;
    in_st = vecs[1].din;
    s8    = 1'b1;
    for (int n = 1; n < 9; n++) begin
      @(negedge clk);
      in_st = ones;
      if (g8 !== 1'b0) early++;
    end
    @(negedge clk);
    s8 = 1'b0;
    chk("held early_ogood", early == 0, 64'(early), 64'd0);
    chk("held ogood", g8 === 1'b1, 64'(g8), 64'd1);
    chk_state("held result", o8, vecs[1].dout);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (g8 !== 1'b0) extra++;
    end
    chk("held extra_ogood", extra == 0, 64'(extra), 64'd0);
    chk_state("held result_kept", o8, vecs[1].dout);
  endtask

  initial begin
    state_t zero;
    checks   = 0;
    failures = 0;
    zero     = '0;

    for (int i = 0; i < NV; i++) begin
      vecs[i].din  = '0;
      vecs[i].dout = '0;
    end
    // row 9 -> 1
    vecs[1].din[0][0]  = 64'h1;
    vecs[1].din[0][3]  = 64'h1;
    vecs[1].dout[0][0] = 64'h1;
    // all ones is a fixed point
    vecs[2].din  = '1;
    vecs[2].dout = '1;
    // row 5 -> 4 in the top column
    vecs[3].din[2][0]  = 64'h8000_0000_0000_0000;
    vecs[3].din[2][2]  = 64'h8000_0000_0000_0000;
    vecs[3].dout[2][2] = 64'h8000_0000_0000_0000;
    // row 1 -> 11 at bit 7
    vecs[4].din[3][0]  = 64'h80;
    vecs[4].dout[3][0] = 64'h80;
    vecs[4].dout[3][1] = 64'h80;
    vecs[4].dout[3][3] = 64'h80;
    // row 2 -> 22 across many columns
    vecs[5].din[4][1]  = 64'hFFFF_0000_FFFF_0000;
    vecs[5].dout[4][1] = 64'hFFFF_0000_FFFF_0000;
    vecs[5].dout[4][2] = 64'hFFFF_0000_FFFF_0000;
    vecs[5].dout[4][4] = 64'hFFFF_0000_FFFF_0000;
    // row 18 -> 2 in bits 8..15
    vecs[6].din[1][1]  = 64'h0000_0000_0000_FF00;
    vecs[6].din[1][4]  = 64'h0000_0000_0000_FF00;
    vecs[6].dout[1][1] = 64'h0000_0000_0000_FF00;

    // Reset with a simultaneous sample request.
    rst   = 1'b1;
    s8    = 1'b1;
    s1    = 1'b0;
    s64   = 1'b0;
    in_st = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    s8  = 1'b0;
    for (int sel = 0; sel < 3; sel++) begin
      chk($sformatf("reset ready%0d", sel), get_ready(sel) === 1'b1, 64'(get_ready(sel)), 64'd1);
      chk($sformatf("reset ogood%0d", sel), get_good(sel) === 1'b0, 64'(get_good(sel)), 64'd0);
      chk_state($sformatf("reset out%0d", sel), get_out(sel), zero);
    end
    @(negedge clk);
    chk("post_reset ready", r8 === 1'b1, 64'(r8), 64'd1);

    for (int i = 0; i < NV; i++) begin
      run_op(0, vecs[i].din, vecs[i].dout, $sformatf("b8 vec%0d", i));
    end
    held_sample();
    reset_mid(0);
    b2b(0, 1000);

    for (int sel = 1; sel < 3; sel++) begin
      for (int i = 0; i < NV; i++) begin
        run_op(sel, vecs[i].din, vecs[i].dout, $sformatf("sel%0d vec%0d", sel, i));
      end
      reset_mid(sel);
      b2b(sel, (sel == 1) ? 20 : 50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha3_chi_inverse.md
SHA3_CHI_INVERSE -- requirements
Module: sha3_chi_inverse

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 8, meaning the number of bit positions (columns of every row) inverted per processing cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have parameter OUTPUT_BUFFER, default 1, meaning 1 = outputs driven from a dedicated result register, 0 = outputs driven directly from the working register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 isa, isb, isc, isd, ise  input  5 x 64 each  chi-output state; slice s = isa..ise (0..4), lane c = index 0..4.
REQ-006 sample  input  1  request to capture the input state and start inversion.
REQ-007 osa, osb, osc, osd, ose  output  5 x 64 each  recovered chi-input state, same slice/lane layout.
REQ-008 ogood  output  1  one-cycle pulse: outputs hold a newly completed result.
REQ-009 oready  output  1  high when the block accepts sample (IDLE state).

Function
REQ-010 Row definition: for slice s and bit k, row value r = sum over c of lane[s][c][k] << c (5 bits).
REQ-011 Forward chi, for reference: y_c = x_c XOR ((NOT x_(c+1 mod 5)) AND x_(c+2 mod 5)).
REQ-012 Output row x SHALL be the unique 5-bit value with chi(x) = input row, for all 5 x 64 rows.
REQ-013 Inversion SHALL use a fixed 32-entry inverse table, replicated 5 x BITS_PER_CYCLE times; no iterative search.
REQ-014 FSM states SHALL be IDLE, BUSY; oready = (state == IDLE).
REQ-015 IDLE with sample=1 SHALL capture all 25 input lanes into the working register, clear the column counter to 0, and move to BUSY.
REQ-016 IDLE with sample=0 SHALL leave all state unchanged.
REQ-017 Each BUSY cycle SHALL replace bit columns [cnt*B, cnt*B+B-1] of the working register, all 5 slices, with their inverted rows, then increment cnt by 1 (B = BITS_PER_CYCLE).
REQ-018 On the BUSY cycle where cnt = 64/B - 1, the FSM SHALL return to IDLE and cnt SHALL wrap to 0.
REQ-019 When OUTPUT_BUFFER=1, the result register SHALL load the fully inverted state on that same edge.
REQ-020 sample asserted while BUSY SHALL be ignored: no capture, no effect on the in-flight operation, no queued request.
REQ-021 Latency: sample=1 in IDLE cycle T SHALL produce ogood=1 in cycle T+64/B+1 only. With B=8, that is T+9.
REQ-022 With B=8, oready SHALL be low in cycles T+1..T+8.
REQ-023 oready SHALL be high in cycle T+64/B+1. A sample in that same cycle SHALL be accepted, giving one result per 64/B+1 cycles back-to-back.
REQ-024 Outputs SHALL hold the last completed result until the next completion; ogood SHALL never be high two consecutive cycles.
REQ-025 When OUTPUT_BUFFER=0, outputs SHALL be valid only while ogood=1 or oready=1 after a completion.
REQ-026 When OUTPUT_BUFFER=0, outputs are undefined during BUSY.

Reset
REQ-027 rst=1 SHALL force state IDLE, cnt 0, ogood 0, and all output lanes and working/result registers to 64'h0, on the next rising edge.
REQ-028 rst mid-operation SHALL abort it with no ogood pulse.
REQ-029 rst SHALL override a simultaneous sample.
REQ-030 The first cycle after rst deasserts SHALL be IDLE with oready=1.

Verification
REQ-031 All-zero input, sample -> ogood pulse at T+9 (B=8), all output lanes 64'h0.
REQ-032 Single-row check: isa[0]=64'h1 and isa[3]=64'h1, all other lanes 0 (row value 9 = chi(1)) -> osa[0]=64'h1, all other lanes 0.
REQ-033 All-ones input (chi(31)=31) -> all output lanes 64'hFFFF_FFFF_FFFF_FFFF.
REQ-034 1000 random states: apply forward chi in the bench model, feed the result, with samples back-to-back every 9 cycles -> every output equals the original state; oready low exactly 8 of every 9 cycles.
REQ-035 Sample held high during BUSY -> exactly one ogood per accepted sample; outputs unchanged by ignored samples.
REQ-036 rst pulsed in cycle T+4 of an operation -> no ogood; outputs 0; a new sample at the first cycle after reset completes normally; all tests repeated for B=1 and B=64 (latency 65 and 2).
